// File: rtl/tlb_inv_ctrl.sv
// tlb_inv_ctrl -- INVTLB sequencer.
//
// This block takes an INVTLB request from the write-back stage. For a legal op
// it reads every TLB entry in turn and clears the E bit of each entry that
// matches. The write-back stage holds the instruction while busy is high and
// releases it on the done pulse.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake with WB
//   req_op/asid/va        INVTLB operands, sampled only when the request is accepted
//   busy                  scan or finish in progress; WB stalls
//   done                  one-cycle completion pulse
//   op_err                valid with done; set when op > 6
//   r_index, r_*          combinational TLB read port
//   inv_we, inv_index     clears the E bit of one entry
module tlb_inv_ctrl #(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned IDX_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       req_op,
   input  logic [9:0]       req_asid,
   input  logic [31:0]      req_va,
   output logic             busy,
   output logic             done,
   output logic             op_err,
   output logic [IDX_W-1:0] r_index,
   input  logic             r_e,
   input  logic [18:0]      r_vppn,
   input  logic [5:0]       r_ps,
   input  logic [9:0]       r_asid,
   input  logic             r_g,
   output logic             inv_we,
   output logic [IDX_W-1:0] inv_index
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [4:0]       op_q, op_d;
   logic [9:0]       asid_q, asid_d;
   logic [18:0]      va_q, va_d;        // holds va[31:13]
   logic             op_err_q, op_err_d;

   logic             vmatch, amatch, match;

   // The low page-offset bits of the VA do not take part in any match.
   logic             unused_va_lo;
   assign unused_va_lo = ^req_va[12:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         asid_q   <= '0;
         va_q     <= '0;
         op_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         asid_q   <= asid_d;
         va_q     <= va_d;
         op_err_q <= op_err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      asid_d   = asid_q;
      va_d     = va_q;
      op_err_d = op_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_op <= 5'd6) begin
                  op_d    = req_op;
                  asid_d  = req_asid;
                  va_d    = req_va[31:13];
                  cnt_d   = '0;
                  state_d = S_SCAN;
               end else begin
                  op_err_d = 1'b1;
                  state_d  = S_FIN;
               end
            end
         end
         S_SCAN: begin
            // IDX_W equals log2(TLBNUM), so the increment wraps to 0 after the last entry.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(TLBNUM - 1)) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            op_err_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A 21-bit page compares only VPPN[18:9] against va[31:22].
   always_comb begin
      vmatch = 1'b0;
      if (r_ps == 6'd12) begin
         vmatch = (r_vppn == va_q);
      end else if (r_ps == 6'd21) begin
         vmatch = (r_vppn[18:9] == va_q[18:9]);
      end
   end

   assign amatch = (r_asid == asid_q);

   always_comb begin
      match = 1'b0;
      case (op_q)
         5'd0, 5'd1: match = 1'b1;
         5'd2:       match = r_g;
         5'd3:       match = ~r_g;
         5'd4:       match = ~r_g & amatch;
         5'd5:       match = ~r_g & amatch & vmatch;
         5'd6:       match = (r_g | amatch) & vmatch;
         default:    match = 1'b0;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q == S_SCAN) || (state_q == S_FIN);
   assign done      = (state_q == S_FIN);
   assign op_err    = op_err_q;
   assign r_index   = cnt_q;
   assign inv_index = cnt_q;
   assign inv_we    = (state_q == S_SCAN) & r_e & match;

endmodule

// File: tb/tb_tlb_inv_ctrl.sv
// Directed bench for tlb_inv_ctrl. It holds a small TLB model behind the read
// port and clears entries on inv_we. Each case compares a hand-computed
// invalidation mask and the cycle-accurate handshake with the DUT outputs.
module tb_tlb_inv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic [9:0]  req_asid;
   logic [31:0] req_va;
   logic        busy, done, op_err;
   logic [3:0]  r_index;
   logic        r_e;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [9:0]  r_asid;
   logic        r_g;
   logic        inv_we;
   logic [3:0]  inv_index;

   logic [15:0] te;
   logic [15:0] tg;
   logic [18:0] tvppn [16];
   logic [5:0]  tps   [16];
   logic [9:0]  tasid [16];

   int n_cmp = 0;
   int n_err = 0;

   tlb_inv_ctrl #(.TLBNUM(16), .IDX_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_asid  (req_asid),
      .req_va    (req_va),
      .busy      (busy),
      .done      (done),
      .op_err    (op_err),
      .r_index   (r_index),
      .r_e       (r_e),
      .r_vppn    (r_vppn),
      .r_ps      (r_ps),
      .r_asid    (r_asid),
      .r_g       (r_g),
      .inv_we    (inv_we),
      .inv_index (inv_index)
   );

   always #5 clk = ~clk;

   assign r_e    = te[r_index];
   assign r_g    = tg[r_index];
   assign r_vppn = tvppn[r_index];
   assign r_ps   = tps[r_index];
   assign r_asid = tasid[r_index];

   // TLB model: the E bit is cleared by the invalidate port.
   always @(posedge clk) begin
      if (inv_we) te[inv_index] <= 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entry i defaults to VPPN i, which matches none of the VAs used here.
   task automatic set_all(input logic e, input logic g, input logic [9:0] asid);
      for (int i = 0; i < 16; i++) begin
         te[i]    = e;
         tg[i]    = g;
         tvppn[i] = 19'(i);
         tps[i]   = 6'd12;
         tasid[i] = asid;
      end
   endtask

   // Issue one legal request and follow it cycle by cycle. The operand and
   // valid lines are scrambled after acceptance and held through FIN.
   task automatic run_req(input string name, input logic [4:0] op, input logic [9:0] asid,
                          input logic [31:0] va, input logic [15:0] exp_mask);
      logic [15:0] obs;
      int guard;
      obs   = '0;
      guard = 0;
      while (!req_ready && guard < 40) begin
         tick();
         guard++;
      end
      check({name, "_ready"}, req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_asid  = asid;
      req_va    = va;
      tick();
      req_op   = 5'd7;
      req_asid = ~asid;
      req_va   = ~va;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         check($sformatf("%s_busy_c%0d", name, c), busy, 1);
         check($sformatf("%s_idx_c%0d", name, c), inv_index, 32'(c - 1));
         check($sformatf("%s_ridx_c%0d", name, c), r_index, 32'(c - 1));
         check($sformatf("%s_done_c%0d", name, c), done, 0);
         obs[c-1] = inv_we;
         tick();
      end
      @(negedge clk);
      check({name, "_fin_done"}, done, 1);
      check({name, "_fin_busy"}, busy, 1);
      check({name, "_fin_err"}, op_err, 0);
      check({name, "_fin_we"}, inv_we, 0);
      check({name, "_fin_ready"}, req_ready, 0);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      check({name, "_post_busy"}, busy, 0);
      check({name, "_post_done"}, done, 0);
      check({name, "_post_ready"}, req_ready, 1);
      check({name, "_mask"}, obs, exp_mask);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_asid  = '0;
      req_va    = '0;
      set_all(1'b1, 1'b0, 10'd0);
      tick();
      tick();
      @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", op_err, 0);
      check("rst_we", inv_we, 0);
      check("rst_inv_idx", inv_index, 0);
      check("rst_r_idx", r_index, 0);
      tick();
      reset = 1'b0;

      // Reset in the fifth SCAN cycle: entries 0..4 are cleared, 5 and later are kept.
      set_all(1'b1, 1'b0, 10'd0);
      req_valid = 1'b1;
      req_op    = 5'd0;
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick(); tick();
      reset = 1'b1;
      @(negedge clk);
      check("rstmid_we", inv_we, 1);
      check("rstmid_idx", inv_index, 4);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_busy", busy, 0);
      check("rstmid_ready", req_ready, 1);
      check("rstmid_we_after", inv_we, 0);
      check("rstmid_done", done, 0);
      check("rstmid_ridx", r_index, 0);
      check("rstmid_emask", te, 16'hFFE0);

      // op 0 clears every entry.
      set_all(1'b1, 1'b0, 10'd0);
      run_req("op0", 5'd0, 10'd0, 32'h0, 16'hFFFF);
      check("op0_emask", te, 16'h0000);

      // op 3 clears the non-global entries 2 and 7 only.
      set_all(1'b1, 1'b1, 10'd0);
      tg[2] = 1'b0;
      tg[7] = 1'b0;
      run_req("op3", 5'd3, 10'd0, 32'h0, 16'h0084);

      // op 5 with asid 5, va 0x1234_6000: va[31:13]=0x091A3, va[31:22]=0x048.
      set_all(1'b1, 1'b0, 10'd5);
      tvppn[4]  = 19'h091A3;
      tvppn[9]  = 19'h091A3;  tasid[9] = 10'd6;
      tvppn[11] = 19'h09055;  tps[11]  = 6'd21;
      tvppn[12] = 19'h09055;                        // ps 12: full compare fails
      run_req("op5", 5'd5, 10'd5, 32'h1234_6000, 16'h0810);

      // op 6: global entry with another ASID matches, E=0 entry is skipped.
      set_all(1'b1, 1'b0, 10'd7);
      tvppn[3]  = 19'h091A3;  tg[3] = 1'b1;  tasid[3] = 10'd9;
      tvppn[8]  = 19'h091A3;  tg[8] = 1'b1;  te[8]    = 1'b0;
      tvppn[10] = 19'h091A3;  tasid[10] = 10'd5;
      tvppn[13] = 19'h091A3;                        // non-global, ASID 7
      run_req("op6", 5'd6, 10'd5, 32'h1234_6000, 16'h0408);

      // Illegal op 7, then a back-to-back legal op 2 at cycle 2.
      set_all(1'b1, 1'b0, 10'd0);
      tg[0]  = 1'b1;
      tg[15] = 1'b1;
      req_valid = 1'b1;
      req_op    = 5'd7;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      check("ill_done", done, 1);
      check("ill_err", op_err, 1);
      check("ill_busy", busy, 1);
      check("ill_we", inv_we, 0);
      check("ill_ready_c1", req_ready, 0);
      tick();
      @(negedge clk);
      check("ill_ready_c2", req_ready, 1);
      check("ill_err_c2", op_err, 0);
      check("ill_done_c2", done, 0);
      check("ill_emask", te, 16'hFFFF);
      run_req("op2", 5'd2, 10'd0, 32'h0, 16'h8001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
